// File: rtl/vector_regfile_v2.sv
// Vector register file: 2 comb read ports, byte-masked write port, MAC accumulator; VRF_BYPASS_EN adds write-to-read forwarding.
// Latency: reads combinational, writes/accumulator visible 1 cycle later; post-reset clear takes DEPTH cycles.
// Backpressure: none; Busy high during the clear, and writes/acc ops issued then are dropped.
module vector_regfile_v2 #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ACC_W  = 2*DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                W_En,
  input  logic [ADDR_W-1:0]   W_Addr,
  input  logic [DATA_W/8-1:0] W_Mask,
  input  logic [DATA_W-1:0]   WR,
  input  logic [ADDR_W-1:0]   R_Addr,
  input  logic [ADDR_W-1:0]   S_Addr,
  output logic [DATA_W-1:0]   R,
  output logic [DATA_W-1:0]   S,
  input  logic [1:0]          Acc_Op,
  input  logic [ACC_W-1:0]    M_ALU_Out,
  output logic [ACC_W-1:0]    R2,
  output logic                Acc_Ovf,
  output logic                Busy
);

  localparam int LANES = DATA_W/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdat;
  logic [DATA_W-1:0]   wr_merged;
  logic [ACC_W:0]      acc_sum;

  // Stored bytes where the mask is clear, incoming bytes where it is set.
  always_comb begin
    wr_merged = mem_q[W_Addr];
    for (int i = 0; i < LANES; i++) begin
      if (W_Mask[i]) wr_merged[8*i +: 8] = WR[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_waddr = W_Addr;
    mem_wdat  = wr_merged;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdat  = '0;
      clr_idx_d = clr_idx_q + ADDR_W'(1);
      if (clr_idx_q == ADDR_W'(DEPTH-1)) state_d = READY;
    end else if (W_En && (W_Mask != '0)) begin
      mem_we = 1'b1;
    end
    busy_d = (state_d == CLEAR);
  end

  always_comb begin
    acc_sum   = {1'b0, acc_q} + {1'b0, M_ALU_Out};
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (state_q == READY) begin
      unique case (Acc_Op)
        2'b01: begin
          acc_d     = M_ALU_Out;
          acc_ovf_d = 1'b0;
        end
        2'b10: begin
          acc_d     = acc_sum[ACC_W-1:0];
          acc_ovf_d = acc_ovf_q | acc_sum[ACC_W];
        end
        2'b11: begin
          acc_d     = '0;
          acc_ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      busy_q    <= 1'b1;
      clr_idx_q <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      clr_idx_q <= clr_idx_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  // Holding reset keeps scrubbing entry 0, matching the idle clear index.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  always_comb begin
    R = mem_q[R_Addr];
    S = mem_q[S_Addr];
`ifdef VRF_BYPASS_EN
    if (W_En && (W_Addr == R_Addr)) R = wr_merged;
    if (W_En && (W_Addr == S_Addr)) S = wr_merged;
`endif
    if (busy_q) begin
      R = '0;
      S = '0;
    end
  end

  assign R2      = acc_q;
  assign Acc_Ovf = acc_ovf_q;
  assign Busy    = busy_q;

endmodule

// File: doc/vector_regfile_v2.md
# vector_regfile_v2

Parametrised vector register file with a multiply-and-add accumulator, successor to the fixed 32×64 vector file in the vector execute stage. Provides two combinational read ports, one byte-masked write port, and a double-width accumulator register for MULANDADD sequences. After reset, a hardware clear sequencer zeroes every entry, one per cycle, and signals `Busy` until the file is usable. It sits between vector decode (reads) and the vector ALU/MAC writeback.

## Interface

Parameters:
- `DATA_W`, 64: vector register width in bits; must be a multiple of 8.
- `DEPTH`, 32: number of registers; must be a power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): register address width.
- `ACC_W`, 2*DATA_W: accumulator width.

Ports:
- `clk`, in, 1: the one clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `W_En`, in, 1: write request.
- `W_Addr`, in, ADDR_W: write register index.
- `W_Mask`, in, DATA_W/8: byte-lane write enables. Bit i covers `WR[8i+7:8i]`.
- `WR`, in, DATA_W: write data.
- `R_Addr`, in, ADDR_W: read port R index.
- `S_Addr`, in, ADDR_W: read port S index.
- `R`, out, DATA_W: read data, port R.
- `S`, out, DATA_W: read data, port S.
- `Acc_Op`, in, 2: accumulator operation. 00 hold, 01 load, 10 accumulate, 11 clear.
- `M_ALU_Out`, in, ACC_W: MAC result operand.
- `R2`, out, ACC_W: accumulator contents.
- `Acc_Ovf`, out, 1: sticky unsigned-carry flag for accumulate.
- `Busy`, out, 1: clear sequence in progress; the block ignores all requests while high.

## Operation

FSM states are CLEAR and READY.

- `rst` high at an edge:
  - state goes to CLEAR and the clear index goes to 0;
  - the accumulator goes to 0 and `Acc_Ovf` goes to 0.
- Behaviour while `rst` is held:
  - the block stays in CLEAR with the index held at 0;
  - entry 0 is rewritten to zero each cycle.
- CLEAR, each edge with `rst` low:
  - writes zero to entry[index], then increments the index;
  - on the edge that clears entry DEPTH-1, moves to READY.
- READY stays in READY until `rst`. Reset mid-clear restarts from index 0.
- `Busy` = (state == CLEAR).
- While `Busy`:
  - `W_En` and `Acc_Op` are ignored (no write, accumulator holds);
  - `R` and `S` are forced to 0;
  - `R2` still shows the accumulator, which is 0 after reset.
- Write, when READY and `W_En`: each lane with its `W_Mask` bit set takes the matching `WR` byte. Unmasked lanes keep their value. `W_Mask` = 0 is a no-op.
- Reads: `R` = entry[`R_Addr`] and `S` = entry[`S_Addr`], combinational. The same address on both ports is legal.
- Accumulator ops, when READY:
  - load: acc ← `M_ALU_Out`, and `Acc_Ovf` ← 0.
  - accumulate: acc ← (acc + `M_ALU_Out`) mod 2^ACC_W. `Acc_Ovf` is set if the ACC_W-bit add carries out; once set it stays set.
  - clear: acc ← 0, and `Acc_Ovf` ← 0.
  - hold: no change.

## Timing

- Reset values, after the first `rst` edge:
  - `Busy` = 1, `R` = 0, `S` = 0, `R2` = 0, `Acc_Ovf` = 0.
- Clear latency: `Busy` falls exactly DEPTH edges after the last `rst`-high edge.
- Write-to-read latency: 1 cycle. Data written at edge N is visible on `R`/`S` after edge N, without the bypass option.
- Write during Busy: dropped and never performed later. Callers must wait for `Busy` = 0.
- Accumulator: `R2` updates on the edge after `Acc_Op` is applied, so latency is 1 cycle.

## Configuration

Macro `VRF_BYPASS_EN`.

- Defined, in READY with `W_En` = 1 and `W_Addr` == `R_Addr`: `R` shows, in the same cycle, the merged value (stored bytes where mask = 0, `WR` bytes where mask = 1). The same rule applies independently to `S`/`S_Addr`.
- Undefined: no forwarding. A read during a write to the same address returns the old contents; the new data appears the next cycle.
- In both cases `R` and `S` are still 0 while `Busy`.

## Test plan

- Reset and clear, DEPTH=32: assert `rst` for 3 cycles, then release.
  - Required: `Busy` stays high for exactly 32 edges after release.
  - Required: every entry then reads 0 on both `R` and `S`.
- Byte-masked write, READY: write entry 5 = 0xFFFF_FFFF_FFFF_FFFF with mask 0xFF, then write entry 5 = 0x1122_3344_5566_7788 with mask 0x0F.
  - Required: `R` (addr 5) = 0xFFFF_FFFF_5566_7788.
- Bypass on the same cycle: write entry 7 = 0xAB (mask 0x01) while `R_Addr` = 7.
  - Required with `VRF_BYPASS_EN`: `R` = 0x…AB in the same cycle.
  - Required without it: `R` = 0x…AB from the next cycle.
- Accumulator: load 2^128−2, accumulate 3, then load 5.
  - Required after the accumulate: `R2` = 1 and `Acc_Ovf` = 1.
  - Required after the load: `R2` = 5 and `Acc_Ovf` = 0.
- Reset mid-clear: assert `rst` at clear index 17.
  - Required: the index restarts at 0.
  - Required: `Busy` lasts a full 32 cycles after release.
  - Required: a `W_En` to entry 3 while `Busy` is dropped, and entry 3 reads 0.
